// File: rtl/leve1_pkg.sv
// Shared types and constants for the LEVE1 issue scoreboard.
// Imported by the interface, the hazard unit and the scoreboard top.
package leve1_pkg;

    localparam int NUM_REG         = 32;
    localparam int MAX_OUTSTANDING = 4;
    localparam int CNT_W           = 3;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        CSR_HOLD = 2'd2
    } sb_state_e;

endpackage

// File: rtl/leve1_scoreboard_if.sv
// Decode-issue / writeback / debug bundle between the pipeline and the scoreboard.
// Handshake: an instruction issues in a cycle where issue_valid && issue_ready; issue_ready may depend combinationally on every issue_* and wb_* input of the same cycle.
interface leve1_scoreboard_if #(
    parameter int NUM_REG = 32,
    parameter int CNT_W   = 3
);
    import leve1_pkg::*;

    logic               issue_valid;
    logic               issue_ready;
    reg_idx_t           issue_rs1;
    logic               issue_rs1_use;
    reg_idx_t           issue_rs2;
    logic               issue_rs2_use;
    reg_idx_t           issue_rd;
    logic               issue_rd_we;
    logic               issue_long;
    logic               issue_csr;
    logic               wb_valid;
    reg_idx_t           wb_rd;
    logic               wb_we;
    logic               wb_long;
    logic               wb_csr;
    logic               flush;
    logic [NUM_REG-1:0] busy_vec;
    logic [CNT_W-1:0]   outstanding;
    sb_state_e          state;

    modport master (
        output issue_valid, issue_rs1, issue_rs1_use, issue_rs2, issue_rs2_use,
               issue_rd, issue_rd_we, issue_long, issue_csr,
               wb_valid, wb_rd, wb_we, wb_long, wb_csr, flush,
        input  issue_ready, busy_vec, outstanding, state
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs1_use, issue_rs2, issue_rs2_use,
               issue_rd, issue_rd_we, issue_long, issue_csr,
               wb_valid, wb_rd, wb_we, wb_long, wb_csr, flush,
        output issue_ready, busy_vec, outstanding, state
    );

endinterface

// File: rtl/leve1_sb_hazard.sv
// Combinational RAW / WAW / structural hazard detection.
// Inputs are the busy bits and count after same-cycle writeback release.
module leve1_sb_hazard
    import leve1_pkg::*;
#(
    parameter int NUM_REG         = 32,
    parameter int CNT_W           = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic [NUM_REG-1:0] busy_eff,
    input  logic [CNT_W-1:0]   cnt_eff,
    input  reg_idx_t           rs1,
    input  logic               rs1_use,
    input  reg_idx_t           rs2,
    input  logic               rs2_use,
    input  reg_idx_t           rd,
    input  logic               rd_we,
    input  logic               long_op,
    output logic               raw,
    output logic               waw,
    output logic               full
);

    assign raw  = (rs1_use && (rs1 != '0) && busy_eff[rs1]) ||
                  (rs2_use && (rs2 != '0) && busy_eff[rs2]);
    assign waw  = rd_we && (rd != '0) && busy_eff[rd];
    assign full = long_op && (cnt_eff == CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/leve1_scoreboard.sv
// Issue controller between decode and execute: busy-bit tracking of long ops,
// hazard stalls, and CSR serialisation (drain, issue, hold until CSR retires).
module leve1_scoreboard
    import leve1_pkg::*;
#(
    parameter int NUM_REG         = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic                clk,
    input  logic                rst,
    leve1_scoreboard_if.slave   sb
);

    sb_state_e          state_q, state_d;
    logic [NUM_REG-1:0] busy_q, clr, set, busy_eff;
    logic [CNT_W-1:0]   cnt_q, cnt_eff;
    logic               wb_long_ret, dec, inc, fire, ready;
    logic               raw, waw, full;

    // A long writeback on an empty counter is an error; saturate rather than wrap.
    assign wb_long_ret = sb.wb_valid && sb.wb_long;
    assign dec         = wb_long_ret && (cnt_q != '0);
    assign cnt_eff     = cnt_q - CNT_W'(dec);
    assign clr         = (wb_long_ret && sb.wb_we && (sb.wb_rd != '0)) ?
                         (NUM_REG'(1) << sb.wb_rd) : '0;
    assign busy_eff    = busy_q & ~clr;

    assign fire = sb.issue_valid && ready;
    assign inc  = fire && sb.issue_long;
    assign set  = (inc && sb.issue_rd_we && (sb.issue_rd != '0)) ?
                  (NUM_REG'(1) << sb.issue_rd) : '0;

    leve1_sb_hazard #(
        .NUM_REG         (NUM_REG),
        .CNT_W           (CNT_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_hazard (
        .busy_eff (busy_eff),
        .cnt_eff  (cnt_eff),
        .rs1      (sb.issue_rs1),
        .rs1_use  (sb.issue_rs1_use),
        .rs2      (sb.issue_rs2),
        .rs2_use  (sb.issue_rs2_use),
        .rd       (sb.issue_rd),
        .rd_we    (sb.issue_rd_we),
        .long_op  (sb.issue_long),
        .raw      (raw),
        .waw      (waw),
        .full     (full)
    );

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            RUN: begin
                ready = !raw && !waw && !full && !(sb.issue_csr && (cnt_eff != '0));
                if (sb.issue_valid && sb.issue_csr && (cnt_eff != '0)) begin
                    state_d = DRAIN;
                end else if (sb.issue_valid && ready && sb.issue_csr) begin
                    state_d = CSR_HOLD;
                end
            end
            DRAIN: begin
                ready = sb.issue_csr && (cnt_eff == '0) && !raw && !waw;
                if (sb.issue_valid && ready) begin
                    state_d = CSR_HOLD;
                end
            end
            CSR_HOLD: begin
                if (sb.wb_valid && sb.wb_csr) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (sb.flush) begin
            ready   = 1'b0;
            state_d = RUN;
        end
    end

    // Clear is applied before set so a same-cycle reissue of rd keeps it busy.
    always_ff @(posedge clk) begin
        if (rst || sb.flush) begin
            state_q <= RUN;
            busy_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_eff | set;
            cnt_q   <= cnt_eff + CNT_W'(inc);
        end
    end

    assign sb.issue_ready = ready;
    assign sb.busy_vec    = busy_q;
    assign sb.outstanding = cnt_q;
    assign sb.state       = state_q;

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(wb_long_ret && (cnt_q == '0)));
    a_clear_busy: assert property (@(posedge clk) disable iff (rst)
        !(wb_long_ret && sb.wb_we && (sb.wb_rd != '0) && !busy_q[sb.wb_rd]));
    a_csr_wb_in_hold: assert property (@(posedge clk) disable iff (rst)
        !(sb.wb_valid && sb.wb_csr && (state_q != CSR_HOLD)));

endmodule

// File: doc/leve1_scoreboard.md
Name: leve1_scoreboard

Overview:
- Issue controller placed between the LEVE1 decode stage and execute.
- Tracks destination registers of in-flight multi-cycle operations (load, mul, div) in a busy-bit scoreboard.
- Stalls decode on RAW, WAW or structural hazards.
- Serialises CSR instructions: drains all outstanding operations before a CSR issues, and blocks further issue until that CSR retires.

Parameters:
- NUM_REG, 32, number of integer registers; x0 is never tracked.
- MAX_OUTSTANDING, 4, maximum in-flight long operations.
- CNT_W, 3, counter width; must satisfy 2**CNT_W > MAX_OUTSTANDING.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- ISSUE_VALID  in  1  decode presents an instruction.
- ISSUE_READY  out  1  instruction may issue; handshake = ISSUE_VALID && ISSUE_READY.
- ISSUE_RS1  in  5  source register 1 index.
- ISSUE_RS1_USE  in  1  rs1 is read.
- ISSUE_RS2  in  5  source register 2 index.
- ISSUE_RS2_USE  in  1  rs2 is read.
- ISSUE_RD  in  5  destination register index.
- ISSUE_RD_WE  in  1  rd is written.
- ISSUE_LONG  in  1  multi-cycle operation.
- ISSUE_CSR  in  1  CSR-class instruction (opcode 7'b1110011).
- WB_VALID  in  1  writeback retires an instruction.
- WB_RD  in  5  retiring destination register.
- WB_WE  in  1  retiring instruction writes rd.
- WB_LONG  in  1  retiring instruction was long.
- WB_CSR  in  1  retiring instruction is CSR-class.
- FLUSH  in  1  pipeline flush; all long units abort in the same cycle.
- BUSY_VEC  out  NUM_REG  registered busy bits; bit 0 is always 0.
- OUTSTANDING  out  CNT_W  registered in-flight long operation count.
- STATE  out  2  current FSM state (debug).

Behaviour:
- Reset (RST=1 at a clock edge): BUSY_VEC=0, OUTSTANDING=0, STATE=RUN. ISSUE_READY is combinational and reads 1 out of reset when no hazard exists. Reset mid-operation discards all tracking.
- Release mask:
  - clr = WB_VALID && WB_LONG && WB_WE && WB_RD!=0 ? onehot(WB_RD) : 0.
  - busy_eff = BUSY_VEC & ~clr. Same-cycle release is visible to issue, so there is no extra bubble.
- Hazards, all evaluated on busy_eff:
  - raw = (RS1_USE && RS1!=0 && busy_eff[RS1]) || (RS2_USE && RS2!=0 && busy_eff[RS2]).
  - waw = RD_WE && RD!=0 && busy_eff[RD].
  - full = ISSUE_LONG && cnt_eff==MAX_OUTSTANDING, where cnt_eff = OUTSTANDING - (WB_VALID && WB_LONG).
- FSM states: RUN=0, DRAIN=1, CSR_HOLD=2.
  - RUN: ISSUE_READY = !raw && !waw && !full && !(ISSUE_CSR && cnt_eff!=0). If ISSUE_VALID && ISSUE_CSR && cnt_eff!=0, go to DRAIN. A CSR handshake goes to CSR_HOLD.
  - DRAIN: ISSUE_READY = ISSUE_CSR && cnt_eff==0 && !raw && !waw. A handshake goes to CSR_HOLD.
  - CSR_HOLD: ISSUE_READY=0. When WB_VALID && WB_CSR, go to RUN; the next instruction may issue on the following cycle.
- Update on handshake with ISSUE_LONG:
  - OUTSTANDING increments.
  - If RD_WE && RD!=0, busy[RD] is set.
- Update on WB_VALID && WB_LONG: OUTSTANDING decrements; clr applies.
- Simultaneous events:
  - Increment and decrement in the same cycle give a net 0.
  - Set and clear of the same register in the same cycle: set wins (clear is applied first).
- Non-long issue never touches the scoreboard; single-cycle results are covered by the decode forward path.
- FLUSH has priority over all updates except RST. It sets BUSY_VEC=0, OUTSTANDING=0, STATE=RUN, and forces ISSUE_READY=0 in that cycle.
- Error conditions, checked by assertions only:
  - long WB with OUTSTANDING==0: counter saturates at 0.
  - clear of a register that is not busy.
  - WB_CSR outside CSR_HOLD.

Decomposition:
- leve1_pkg:
  - typedef sb_state_e {RUN, DRAIN, CSR_HOLD}.
  - typedef reg_idx_t (logic [4:0]).
  - localparam OPC_SYSTEM = 7'b1110011.
- Sub-module leve1_sb_hazard: purely combinational raw/waw/full evaluation on busy_eff. Keeps the sequential top small and makes the hazard logic unit-testable.

Test Plan:
- RAW: issue long with RD=5 at cycle 0; at cycle 1 issue with RS1=5 -> ISSUE_READY=0. WB RD=5 at cycle 3 -> ISSUE_READY=1 in the same cycle 3; BUSY_VEC[5]=0 at cycle 4.
- Structural: issue 4 long ops to x1..x4 back to back -> OUTSTANDING=4. A 5th long op stalls; an independent non-long op with RS1=7 issues. A simultaneous WB lets the 5th issue and OUTSTANDING stays 4.
- CSR serialisation: 2 long ops outstanding, then CSR presented -> STATE=DRAIN, ready=0. Both WBs complete -> CSR issues in the cycle OUTSTANDING reaches 0 (via cnt_eff), STATE=CSR_HOLD. A following ADD stalls until WB_CSR; the ADD issues the cycle after.
- x0 handling: long op with RD=0, then reader with RS1=0 -> BUSY_VEC stays 0, no stall; OUTSTANDING=1 until its WB.
- Same-cycle set/clear: WB of long x9 coincides with issue of long RD=9 -> BUSY_VEC[9]=1 next cycle, OUTSTANDING unchanged.
- FLUSH/RST: flush with busy x3, x4 and STATE=CSR_HOLD -> next cycle BUSY_VEC=0, OUTSTANDING=0, STATE=RUN. Repeat with RST=1 mid-DRAIN -> same reset values.
